// File: rtl/seq_det_ctrl.sv
// Word-level controller for a serial "0101" Mealy detector: serialises words MSB-first and reports match count/first position.
// Optional sticky threshold interrupt is built when SEQ_CTRL_IRQ_EN is defined.
module seq_det_ctrl #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4,
  parameter int THRESH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORD_W-1:0]       in_data,
  input  logic                    abort,
  output logic                    det_din,
  output logic                    det_reset,
  input  logic                    det_y,
  output logic                    done,
  output logic [CNT_W-1:0]        match_cnt,
  output logic [$clog2(WORD_W):0] first_pos,
  output logic                    irq,
  input  logic                    irq_clr
);

  localparam int POS_W = $clog2(WORD_W) + 1;
  localparam logic [POS_W-1:0] POS_NONE = {POS_W{1'b1}};
  localparam logic [POS_W-1:0] LAST_BIT = POS_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [WORD_W-1:0] shreg_r;
  logic [WORD_W-1:0] shreg_nxt_s;
  logic [POS_W-1:0]  bitcnt_r;
  logic [POS_W-1:0]  bitcnt_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic [POS_W-1:0]  pos_r;
  logic [POS_W-1:0]  pos_nxt_s;
  logic              hit_r;
  logic              hit_nxt_s;
  logic              load_s;
  logic              done_r;
  logic [CNT_W-1:0]  match_cnt_r;
  logic [POS_W-1:0]  first_pos_r;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  // Next-state and work-register update; load_s marks the last bit of a completed word
  always_comb begin
    state_nxt_s  = state_r;
    shreg_nxt_s  = shreg_r;
    bitcnt_nxt_s = bitcnt_r;
    cnt_nxt_s    = cnt_r;
    pos_nxt_s    = pos_r;
    hit_nxt_s    = hit_r;
    load_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nxt_s  = SHIFT;
          shreg_nxt_s  = in_data;
          bitcnt_nxt_s = '0;
          cnt_nxt_s    = '0;
          pos_nxt_s    = POS_NONE;
          hit_nxt_s    = 1'b0;
        end else begin
          state_nxt_s  = IDLE;
        end
      end
      SHIFT: begin
        if (abort) begin
          // Abort discards this bit's match and leaves results untouched
          state_nxt_s = IDLE;
        end else begin
          if (det_y) begin
            cnt_nxt_s = sat_inc(cnt_r);
            if (!hit_r) begin
              pos_nxt_s = bitcnt_r;
              hit_nxt_s = 1'b1;
            end else begin
              pos_nxt_s = pos_r;
              hit_nxt_s = hit_r;
            end
          end else begin
            cnt_nxt_s = cnt_r;
          end
          shreg_nxt_s  = {shreg_r[WORD_W-2:0], 1'b0};
          bitcnt_nxt_s = bitcnt_r + POS_W'(1);
          if (bitcnt_r == LAST_BIT) begin
            state_nxt_s = DONE;
            load_s      = 1'b1;
          end else begin
            state_nxt_s = SHIFT;
          end
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and work registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r  <= IDLE;
      shreg_r  <= '0;
      bitcnt_r <= '0;
      cnt_r    <= '0;
      pos_r    <= POS_NONE;
      hit_r    <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      shreg_r  <= shreg_nxt_s;
      bitcnt_r <= bitcnt_nxt_s;
      cnt_r    <= cnt_nxt_s;
      pos_r    <= pos_nxt_s;
      hit_r    <= hit_nxt_s;
    end
  end

  // Result registers: loaded with the final work values as the FSM enters DONE
  always_ff @(posedge clk) begin
    if (!reset) begin
      done_r      <= 1'b0;
      match_cnt_r <= '0;
      first_pos_r <= POS_NONE;
    end else begin
      done_r <= load_s;
      if (load_s) begin
        match_cnt_r <= cnt_nxt_s;
        first_pos_r <= pos_nxt_s;
      end else begin
        match_cnt_r <= match_cnt_r;
        first_pos_r <= first_pos_r;
      end
    end
  end

  // Detector stays in reset outside SHIFT so each word starts from s0
  assign in_ready  = reset && (state_r == IDLE);
  assign det_reset = !reset || (state_r != SHIFT);
  assign det_din   = (state_r == SHIFT) ? shreg_r[WORD_W-1] : 1'b1;
  assign done      = done_r;
  assign match_cnt = match_cnt_r;
  assign first_pos = first_pos_r;

`ifdef SEQ_CTRL_IRQ_EN
  logic irq_r;
  logic irq_set_s;

  assign irq_set_s = done_r && (32'(match_cnt_r) >= 32'(THRESH));

  // Sticky interrupt; a set in the DONE cycle wins over a coincident clear
  always_ff @(posedge clk) begin
    if (!reset) begin
      irq_r <= 1'b0;
    end else if (irq_set_s) begin
      irq_r <= 1'b1;
    end else if (irq_clr) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= irq_r;
    end
  end

  assign irq = irq_r;
`else
  logic unused_s;

  assign unused_s = ^{irq_clr, 32'(THRESH)};
  assign irq      = 1'b0;
`endif

endmodule
